// File: rtl/mem_arbiter_nport.sv
// mem_arbiter_nport: N-port memory arbiter (fixed priority or round robin), one
// outstanding transaction, registered command, read data captured after RD_LATENCY.
module mem_arbiter_nport #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 2,
    parameter int RD_LATENCY = 1,
    parameter int MODE       = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            busy_o,
    input  logic [DATA_WIDTH-1:0]           mem_value_i,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_value_o,
    output logic                            mem_rd_en_o,
    output logic                            mem_wr_en_o,
    output logic                            mem_enable_o
);
    localparam int PW = $clog2(NUM_PORTS);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t               state;
    logic [PW-1:0]        ptr, win, win_r;
    logic [NUM_PORTS-1:0] mask, above;
    logic [2:0]           cnt;
    logic                 we_r;
    // Round robin prefers requesters above the last grant, else wraps to the lowest one.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_PORTS; i++) mask[i] = (MODE != 0) && (i > int'(ptr));
        above = req_i & mask;
        win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) if ((|above) ? above[i] : req_i[i]) win = PW'(i);
    end
    assign mem_enable_o = mem_rd_en_o | mem_wr_en_o;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= PW'(NUM_PORTS - 1);
            win_r       <= '0;
            we_r        <= 1'b0;
            gnt_o       <= '0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            mem_addr_o  <= '0;
            mem_value_o <= '0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
        end else begin
            gnt_o       <= '0;
            rvalid_o    <= '0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            if (state == IDLE) begin
                if (|req_i) begin
                    state      <= WAIT;
                    busy_o     <= 1'b1;
                    win_r      <= win;
                    ptr        <= win;
                    we_r       <= we_i[win];
                    cnt        <= 3'(RD_LATENCY);
                    gnt_o      <= NUM_PORTS'(1) << win;
                    mem_addr_o <= addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
                    if (we_i[win]) begin
                        mem_wr_en_o <= 1'b1;
                        mem_value_o <= wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        mem_rd_en_o <= 1'b1;
                    end
                end
            end else if (we_r || cnt == 3'd0) begin
                state  <= IDLE;
                busy_o <= 1'b0;
                if (!we_r) begin
                    rdata_o  <= mem_value_i;
                    rvalid_o <= NUM_PORTS'(1) << win_r;
                end
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_nport.sv
// tb_mem_arbiter_nport: random traffic against a cycle-schedule model, plus
// literal scenarios for a round-robin (N=2,L=1) and a fixed-priority (N=3,L=3) instance.
module tb_mem_arbiter_nport;
    localparam int AW = 8, DW = 16, N = 2, L = 1, MAXC = 4096;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_a = '0, we_a = '0, gnt_a, rv_a;
    logic [N*AW-1:0] addr_a = '0;
    logic [N*DW-1:0] wdata_a = '0;
    logic [DW-1:0]   rdata_a, mem_in_a = '0, mout_a;
    logic [AW-1:0]   maddr_a;
    logic            busy_a, rd_a, wr_a, en_a;

    logic [2:0]      req_b = '0, we_b = '0, gnt_b, rv_b;
    logic [3*AW-1:0] addr_b = '0;
    logic [3*DW-1:0] wdata_b = '0;
    logic [DW-1:0]   rdata_b, mem_in_b = '0, mout_b;
    logic [AW-1:0]   maddr_b;
    logic            busy_b, rd_b, wr_b, en_b;

    mem_arbiter_nport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(N), .RD_LATENCY(L), .MODE(1)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a), .wdata_i(wdata_a),
        .gnt_o(gnt_a), .rvalid_o(rv_a), .rdata_o(rdata_a), .busy_o(busy_a), .mem_value_i(mem_in_a),
        .mem_addr_o(maddr_a), .mem_value_o(mout_a), .mem_rd_en_o(rd_a), .mem_wr_en_o(wr_a), .mem_enable_o(en_a));

    mem_arbiter_nport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(3), .RD_LATENCY(3), .MODE(0)) u_fp (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b), .wdata_i(wdata_b),
        .gnt_o(gnt_b), .rvalid_o(rv_b), .rdata_o(rdata_b), .busy_o(busy_b), .mem_value_i(mem_in_b),
        .mem_addr_o(maddr_b), .mem_value_o(mout_b), .mem_rd_en_o(rd_b), .mem_wr_en_o(wr_b), .mem_enable_o(en_b));

    int cyc = 0, tests = 0, fails = 0;
    int e_gnt[MAXC], e_rv[MAXC], e_addr[MAXC], e_wval[MAXC], memval[MAXC];
    bit e_rd[MAXC], e_wr[MAXC], e_busy[MAXC], e_rst[MAXC];
    int free_at = 0, last = N - 1;
    int h_addr = 0, h_val = 0, h_rdata = 0;
    int pend[N], pa[N], pw[N], pd[N];

    // Model of u_rr: at each edge, decide from the sampled inputs what every later cycle must show.
    initial forever begin
        @(posedge clk);
        memval[cyc] = int'(mem_in_a);
        if (rst) begin
            for (int k = cyc + 1; k <= cyc + 12; k++) begin
                e_gnt[k] = 0; e_rv[k] = 0; e_rd[k] = 0; e_wr[k] = 0; e_busy[k] = 0; e_rst[k] = 0;
            end
            e_rst[cyc+1] = 1;
            free_at = cyc + 1;
            last = N - 1;
        end else if (cyc >= free_at && req_a != 0) begin
            int w;
            w = -1;
            for (int i = 1; i <= N; i++)
                if (w < 0 && ((int'(req_a) >> ((last + i) % N)) & 1) == 1) w = (last + i) % N;
            last = w;
            e_gnt[cyc+1] = 1 << w;
            e_addr[cyc+1] = int'(AW'(addr_a >> (w * AW)));
            if (((int'(we_a) >> w) & 1) == 1) begin
                e_wr[cyc+1] = 1;
                e_wval[cyc+1] = int'(DW'(wdata_a >> (w * DW)));
                e_busy[cyc+1] = 1;
                free_at = cyc + 2;
            end else begin
                e_rd[cyc+1] = 1;
                for (int k = 1; k <= L + 1; k++) e_busy[cyc+k] = 1;
                e_rv[cyc+2+L] = 1 << w;
                free_at = cyc + 2 + L;
            end
        end
        cyc = cyc + 1;
    end

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        int k;
        k = cyc;
        if (e_rst[k]) begin h_addr = 0; h_val = 0; h_rdata = 0; end
        if (e_gnt[k] != 0) h_addr = e_addr[k];
        if (e_wr[k]) h_val = e_wval[k];
        if (e_rv[k] != 0) h_rdata = memval[k-1];
        cmp("m_gnt", int'(gnt_a), e_gnt[k]);
        cmp("m_rvalid", int'(rv_a), e_rv[k]);
        cmp("m_rd_en", int'(rd_a), int'(e_rd[k]));
        cmp("m_wr_en", int'(wr_a), int'(e_wr[k]));
        cmp("m_enable", int'(en_a), int'(e_rd[k] | e_wr[k]));
        cmp("m_busy", int'(busy_a), int'(e_busy[k]));
        cmp("m_addr", int'(maddr_a), h_addr);
        cmp("m_wval", int'(mout_a), h_val);
        cmp("m_rdata", int'(rdata_a), h_rdata);
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        mem_in_a = DW'($urandom);
        mem_in_b = DW'($urandom);
    endtask

    task automatic do_reset();
        req_a = '0; req_b = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        cmp("rst_gnt", int'(gnt_a), 0);
        cmp("rst_busy", int'(busy_a), 0);
        cmp("rst_rdata", int'(rdata_a), 0);
        cmp("rst_fp_busy", int'(busy_b), 0);
        // Single write from port 0
        req_a = 2'b01; we_a = 2'b01; addr_a = 16'h0010; wdata_a = 32'h0000_BEEF;
        tick();
        req_a = '0;
        cmp("wr_gnt", int'(gnt_a), 'b01);
        cmp("wr_en", int'(wr_a), 1);
        cmp("wr_addr", int'(maddr_a), 'h10);
        cmp("wr_val", int'(mout_a), 'hBEEF);
        cmp("wr_busy1", int'(busy_a), 1);
        tick();
        cmp("wr_busy2", int'(busy_a), 0);
        // Single read from port 1
        do_reset();
        req_a = 2'b10; we_a = 2'b00; addr_a = 16'h2200;
        tick();
        req_a = '0;
        cmp("rd_gnt", int'(gnt_a), 'b10);
        cmp("rd_en", int'(rd_a), 1);
        cmp("rd_addr", int'(maddr_a), 'h22);
        tick();
        mem_in_a = 16'h1234;
        cmp("rd_rv_early", int'(rv_a), 0);
        tick();
        cmp("rd_rvalid", int'(rv_a), 'b10);
        cmp("rd_rdata", int'(rdata_a), 'h1234);
        // Round robin alternation with both ports writing continuously
        do_reset();
        req_a = 2'b11; we_a = 2'b11; addr_a = 16'h2211; wdata_a = 32'h2222_1111;
        for (int i = 1; i <= 8; i++) begin
            tick();
            cmp("rr_gnt", int'(gnt_a), (i % 2 == 0) ? 0 : ((i == 1 || i == 5) ? 1 : 2));
        end
        // Reset in the middle of a read aborts it
        do_reset();
        req_a = 2'b01; we_a = 2'b00; addr_a = 16'h005A;
        tick();
        req_a = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp("ab_rvalid", int'(rv_a), 0);
        cmp("ab_busy", int'(busy_a), 0);
        cmp("ab_addr", int'(maddr_a), 0);
        cmp("ab_gnt", int'(gnt_a), 0);
        req_a = 2'b11; we_a = 2'b00;
        tick();
        req_a = 2'b10;
        cmp("ab_first", int'(gnt_a), 'b01);
        tick();
        tick();
        tick();
        // Random traffic; each port holds its request until granted
        do_reset();
        for (int p = 0; p < N; p++) pend[p] = 0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < N; p++) begin
                if (((int'(gnt_a) >> p) & 1) == 1) pend[p] = int'($urandom_range(0, 1));
                else if (pend[p] == 0) pend[p] = ($urandom_range(0, 2) == 0) ? 1 : 0;
                if (((int'(gnt_a) >> p) & 1) == 1 || ((int'(req_a) >> p) & 1) == 0) begin
                    pw[p] = int'($urandom_range(0, 1));
                    pa[p] = int'($urandom_range(0, 255));
                    pd[p] = int'($urandom_range(0, 65535));
                end
            end
            req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
            for (int p = 0; p < N; p++) begin
                req_a   = req_a | (N'(pend[p]) << p);
                we_a    = we_a | (N'(pw[p]) << p);
                addr_a  = addr_a | ((N*AW)'(pa[p]) << (p * AW));
                wdata_a = wdata_a | ((N*DW)'(pd[p]) << (p * DW));
            end
        end
        // Fixed priority, three ports, read latency 3
        do_reset();
        req_b = 3'b100; we_b = 3'b000; addr_b = 24'h33_0000;
        tick();
        cmp("l3_gnt1", int'(gnt_b), 'b100);
        cmp("l3_addr", int'(maddr_b), 'h33);
        cmp("l3_rd", int'(rd_b), 1);
        tick();
        tick();
        tick();
        mem_in_b = 16'hC0DE;
        cmp("l3_busy4", int'(busy_b), 1);
        cmp("l3_rv4", int'(rv_b), 0);
        tick();
        cmp("l3_rvalid", int'(rv_b), 'b100);
        cmp("l3_rdata", int'(rdata_b), 'hC0DE);
        cmp("l3_gnt5", int'(gnt_b), 0);
        cmp("l3_busy5", int'(busy_b), 0);
        tick();
        cmp("l3_gnt6", int'(gnt_b), 'b100);
        do_reset();
        req_b = 3'b011; we_b = 3'b011; wdata_b = 48'h0000_2222_1111;
        for (int i = 1; i <= 5; i++) begin
            tick();
            cmp("fp_gnt", int'(gnt_b), (i % 2 == 1) ? 'b001 : 0);
        end
        req_b = 3'b010;
        tick();
        tick();
        cmp("fp_gnt1", int'(gnt_b), 'b010);
        cmp("fp_wval", int'(mout_b), 'h2222);
        req_b = '0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_nport.md
MEM_ARBITER_NPORT -- requirements
Module: mem_arbiter_nport

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory data width.
REQ-003 SHALL have parameter NUM_PORTS, default 2, number of requesters (legal range 2..8).
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from mem_rd_en_o to valid mem_value_i (legal range 1..7).
REQ-005 SHALL have parameter MODE, default 1; 0 = fixed priority, 1 = round robin.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- req_i  in  NUM_PORTS  per-port request.
- we_i  in  NUM_PORTS  per-port write (1) / read (0).
- addr_i  in  NUM_PORTS*ADDR_WIDTH  packed per-port address; port k occupies slice k.
- wdata_i  in  NUM_PORTS*DATA_WIDTH  packed per-port write data.
- gnt_o  out  NUM_PORTS  one-hot grant pulse.
- rvalid_o  out  NUM_PORTS  one-hot read-data-valid pulse.
- rdata_o  out  DATA_WIDTH  read data, shared by all ports.
- busy_o  out  1  arbiter not in IDLE.
- mem_value_i  in  DATA_WIDTH  memory read data.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_value_o  out  DATA_WIDTH  memory write data.
- mem_rd_en_o  out  1  memory read strobe.
- mem_wr_en_o  out  1  memory write strobe.
- mem_enable_o  out  1  mem_rd_en_o OR mem_wr_en_o.

Function
REQ-008 SHALL implement FSM states IDLE and WAIT; arbitration occurs only in IDLE.
REQ-009 In IDLE with any req_i bit set at cycle t, SHALL select winner w, register the command, and enter WAIT; in cycle t+1 gnt_o[w]=1, mem_addr_o=addr_i[w], plus mem_wr_en_o=1 with mem_value_o=wdata_i[w] (write) or mem_rd_en_o=1 (read).
REQ-010 gnt_o, mem_rd_en_o and mem_wr_en_o SHALL each be high for exactly one cycle per transaction.
REQ-011 MODE=0 SHALL grant the lowest-index requesting port.
REQ-012 MODE=1 SHALL grant the first requesting port searching upward, with wrap-around, from last-granted+1; the pointer SHALL update only on grant.
REQ-013 Write: WAIT SHALL last 1 cycle (t+1); IDLE at t+2; one write per 2 cycles maximum.
REQ-014 Read: WAIT SHALL last RD_LATENCY+1 cycles via down-counter loaded with RD_LATENCY at grant; when count=0, mem_value_i SHALL be captured into rdata_o and the FSM SHALL return to IDLE.
REQ-015 rvalid_o[w] SHALL be high for one cycle at t+2+RD_LATENCY; rdata_o SHALL hold its value until the next capture.
REQ-016 Requesters SHALL hold req_i, we_i, addr_i and wdata_i until gnt_o; inputs SHALL be sampled only in the IDLE grant cycle, and later changes SHALL have no effect.
REQ-017 A req_i still high in the IDLE cycle after completion SHALL be treated as a new request.
REQ-018 mem_addr_o and mem_value_o SHALL hold their last values between transactions; busy_o=1 exactly in WAIT.

Reset
REQ-019 On rst_i=1: state IDLE, counter 0, all outputs 0, RR pointer = NUM_PORTS-1 (port 0 preferred first).
REQ-020 Reset during WAIT SHALL abort the transaction with no rvalid_o, and SHALL take precedence over any simultaneous grant or capture.

Verification
REQ-021 Write (N=2): port0 req, we=1, addr 0x10, wdata 0xBEEF at cycle 0 -> cycle 1: gnt_o=01, mem_wr_en_o=1, mem_addr_o=0x10, mem_value_o=0xBEEF; busy_o high in cycle 1 only.
REQ-022 Read (L=1): port1 read addr 0x22 at cycle 0, memory drives 0x1234 in cycle 2 -> mem_rd_en_o in cycle 1; rvalid_o=10 and rdata_o=0x1234 in cycle 3.
REQ-023 MODE=1, both ports continuously requesting writes -> grants at cycles 1,3,5,7 go to ports 0,1,0,1.
REQ-024 MODE=0, both ports continuously requesting -> port 0 granted every transaction; port 1 granted only once port 0 drops req_i.
REQ-025 Read from port 0 with rst_i pulsed in cycle 2 (L=1) -> no rvalid_o, all outputs 0 in cycle 3; simultaneous requests afterward -> port 0 granted first.
REQ-026 N=3, L=3: port2 read at cycle 0 -> gnt_o=100 in cycle 1; rvalid_o=100 in cycle 5; next grant no earlier than cycle 6.
